// File: rtl/boot_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | boot_pkg : shared state encoding and stream layout for the boot loader |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package boot_pkg;

  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [15:0] hdr_field_t;

  typedef struct packed {
    hdr_field_t pc;
    hdr_field_t n;
  } boot_header_t;

  typedef enum logic [3:0] {
    S_H_PC0 = 4'd0,
    S_H_PC1 = 4'd1,
    S_H_N0  = 4'd2,
    S_H_N1  = 4'd3,
    S_DATA  = 4'd4,
    S_WRITE = 4'd5,
    S_CSUM  = 4'd6,
    S_HOLD  = 4'd7,
    S_RUN   = 4'd8,
    S_ERROR = 4'd9
  } boot_state_t;

endpackage
`default_nettype wire

// File: rtl/boot_word_assembler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | boot_word_assembler : gathers little-endian bytes into one data word  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module boot_word_assembler
  import boot_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [7:0]            byte_data,
  input  logic                  byte_fire,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] byte_idx;

  assign word_valid = byte_fire && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

  // Shifting in from the top leaves the first byte in the least significant lane.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (byte_fire) begin
      byte_idx <= byte_idx + IDX_W'(1);
      word     <= {byte_data, word[DATA_WIDTH-1:8]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | boot_loader : parses a boot stream, programs SRAM, then releases core |
// | Option macro: BOOT_CHECKSUM_EN (trailing XOR byte check)              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int RESET_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reload,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_en,
  output logic                  sram_sel,
  output logic                  sram_we,
  output logic                  bus_own,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH-1:0] pc_init,
  output logic                  done,
  output logic                  error
);

  localparam logic [31:0] DEPTH  = 32'(1) << ADDR_WIDTH;
  localparam int          HOLD_W = (RESET_HOLD > 2) ? $clog2(RESET_HOLD) : 1;

  boot_state_t            state, state_nxt, end_state;
  logic [7:0]             hdr_lo;
  hdr_field_t             n_now, n_words;
  logic [ADDR_WIDTH:0]    word_cnt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   accept, data_fire, word_valid, last_word, hold_done;
  logic [DATA_WIDTH-1:0]  asm_word;

  assign accept    = in_valid && in_ready;
  assign data_fire = accept && (state == S_DATA);
  assign n_now     = {in_data, hdr_lo};
  assign last_word = (32'(word_cnt) + 32'd1) == 32'(n_words);
  assign hold_done = (32'(hold_cnt) + 32'd1) >= 32'(RESET_HOLD);

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum;

  assign end_state = S_CSUM;

  always_ff @(posedge clk) begin
    if (reset || reload) begin
      csum <= '0;
    end else if (accept && (state != S_CSUM)) begin
      csum <= csum ^ in_data;
    end
  end
`else
  assign end_state = S_HOLD;
`endif

  boot_word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (reload),
    .byte_data  (in_data),
    .byte_fire  (data_fire),
    .word       (asm_word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset || reload) state <= S_H_PC0;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_H_PC0: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_H_PC1;
      end
      S_H_PC1: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_H_N0;
      end
      S_H_N0: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_H_N1;
      end
      S_H_N1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (n_now == '0)                 state_nxt = end_state;
          else if (32'(n_now) > DEPTH)     state_nxt = S_ERROR;
          else                             state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (word_valid) state_nxt = S_WRITE;
      end
      S_WRITE: state_nxt = last_word ? end_state : S_DATA;
      S_CSUM: begin
`ifdef BOOT_CHECKSUM_EN
        in_ready = 1'b1;
        if (in_valid) state_nxt = (in_data == csum) ? S_HOLD : S_ERROR;
`else
        state_nxt = S_ERROR;
`endif
      end
      S_HOLD:  if (hold_done) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_ERROR;
    endcase
  end

  // Header capture, word counter and post-load hold timer.
  always_ff @(posedge clk) begin
    if (reset || reload) begin
      hdr_lo   <= '0;
      n_words  <= '0;
      pc_init  <= '0;
      word_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      if (accept && ((state == S_H_PC0) || (state == S_H_N0))) hdr_lo <= in_data;
      if (accept && (state == S_H_PC1)) pc_init <= ADDR_WIDTH'(n_now);
      if (accept && (state == S_H_N1))  n_words <= n_now;
      if (state == S_WRITE) word_cnt <= word_cnt + (ADDR_WIDTH + 1)'(1);
      hold_cnt <= (state == S_HOLD) ? hold_cnt + HOLD_W'(1) : '0;
    end
  end

  assign sram_en   = (state == S_WRITE);
  assign sram_sel  = sram_en;
  assign sram_we   = sram_en;
  assign sram_addr = word_cnt[ADDR_WIDTH-1:0];
  assign sram_data = asm_word;
  assign bus_own   = !((state == S_RUN) || (state == S_ERROR));
  assign cpu_reset = (state != S_RUN);
  assign done      = (state == S_RUN);
  assign error     = (state == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_boot_loader : randomized stream bench with a stream-level model     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_boot_loader;

  localparam int AW    = 15;
  localparam int DW    = 32;
  localparam int RH    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1, reload = 1'b0, in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, sram_en, sram_sel, sram_we, bus_own, cpu_reset, done, error;
  logic [AW-1:0] sram_addr, pc_init;
  logic [DW-1:0] sram_data;

  always #5 clk = ~clk;

  boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_HOLD(RH)) dut (
    .clk(clk), .reset(reset), .reload(reload), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sram_addr(sram_addr), .sram_data(sram_data), .sram_en(sram_en),
    .sram_sel(sram_sel), .sram_we(sram_we), .bus_own(bus_own), .cpu_reset(cpu_reset),
    .pc_init(pc_init), .done(done), .error(error)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Stream-level model: position in the byte stream plus pending write / hold phases.
  bit          m_valid = 0, m_err, m_run, m_write, m_csum;
  int          m_hold, m_bytes, m_words;
  logic [15:0] m_pc, m_n;
  logic [7:0]  m_xor;
  logic [31:0] m_word, m_wdata;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  int cyc = 0, last_write_cyc = -1, first_run_cyc = -1;

  function automatic void model_reset();
    m_valid = 1; m_err = 0; m_run = 0; m_write = 0; m_csum = 0;
    m_hold = 0; m_bytes = 0; m_words = 0; m_pc = 0; m_n = 0; m_xor = 0;
    m_word = 0; m_wdata = 0;
  endfunction

  function automatic void model_finish();
`ifdef BOOT_CHECKSUM_EN
    m_csum = 1;
`else
    m_hold = RH;
`endif
  endfunction

  initial forever begin
    bit exp_ready;
    @(negedge clk);
    cyc++;
    if (m_valid) begin
      exp_ready = !(m_err || m_run || m_write || (m_hold > 0));
      chk("in_ready", in_ready, exp_ready);
      chk("sram_en", sram_en, m_write);
      chk("sram_sel", sram_sel, m_write);
      chk("sram_we", sram_we, m_write);
      chk("bus_own", bus_own, !(m_run || m_err));
      chk("cpu_reset", cpu_reset, !m_run);
      chk("done", done, m_run);
      chk("error", error, m_err);
      if (m_write) begin
        chk("sram_addr", sram_addr, m_words[AW-1:0]);
        chk("sram_data", sram_data, m_wdata);
      end
      if (m_run) chk("pc_init", pc_init, m_pc[AW-1:0]);
    end
    if (sram_en) begin
      log_addr.push_back(sram_addr);
      log_data.push_back(sram_data);
      last_write_cyc = cyc;
    end
    if (done && first_run_cyc < 0) first_run_cyc = cyc;
    // Advance using the inputs the DUT samples on the coming rising edge.
    if (reset || reload) begin
      model_reset();
      log_addr.delete(); log_data.delete();
      last_write_cyc = -1; first_run_cyc = -1;
    end else if (m_valid && !(m_err || m_run)) begin
      if (m_write) begin
        m_write = 0;
        m_words++;
        if (m_words == int'(m_n)) model_finish();
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_run = 1;
      end else if (in_valid) begin
        if (m_csum) begin
          m_csum = 0;
          if (in_data == m_xor) m_hold = RH;
          else                  m_err = 1;
        end else begin
          m_xor ^= in_data;
          m_bytes++;
          case (m_bytes)
            1: m_pc[7:0]  = in_data;
            2: m_pc[15:8] = in_data;
            3: m_n[7:0]   = in_data;
            4: begin
              m_n[15:8] = in_data;
              if (m_n == 0)                 model_finish();
              else if (int'(m_n) > DEPTH)   m_err = 1;
            end
            default: begin
              m_word = {in_data, m_word[31:8]};
              if ((m_bytes - 4) % 4 == 0) begin
                m_write = 1;
                m_wdata = m_word;
              end
            end
          endcase
        end
      end
    end
  end

  logic [31:0] wds[16];
  logic [7:0]  strm[$];

  function automatic void build(input logic [15:0] pc, input logic [15:0] n,
                                input int nw, input bit bad_csum);
    logic [7:0] x;
    x = 8'h00;
    strm.delete();
    strm.push_back(pc[7:0]); strm.push_back(pc[15:8]);
    strm.push_back(n[7:0]);  strm.push_back(n[15:8]);
    for (int i = 0; i < nw; i++)
      for (int k = 0; k < 4; k++) strm.push_back(wds[i][8*k +: 8]);
    foreach (strm[i]) x ^= strm[i];
`ifdef BOOT_CHECKSUM_EN
    strm.push_back(bad_csum ? (x ^ 8'h01) : x);
`else
    if (bad_csum) x = 8'h00;
`endif
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int w;
    while (int'($urandom_range(99)) < gap_pct) begin
      in_data = 8'($urandom);
      tick();
    end
    in_data  = b;
    in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL byte_accept: in_ready stayed 0, required 1 within 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input int limit, input int gap_pct);
    for (int i = 0; i < strm.size() && i < limit; i++) send_byte(strm[i], gap_pct);
  endtask

  task automatic wait_end(input int max_cyc);
    int w;
    w = 0;
    while (!(done || error) && w < max_cyc) begin
      tick();
      w++;
    end
    if (!(done || error)) begin
      checks++; errors++;
      $display("FAIL load_end: done/error still 0 after %0d cycles, required 1", max_cyc);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse_reload();
    in_valid = 1'b0; reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic check_log(input string name, input int nw);
    chk({name, "_nwrites"}, log_data.size(), nw);
    for (int i = 0; i < nw && i < log_data.size(); i++) begin
      chk({name, "_addr"}, log_addr[i], i);
      chk({name, "_data"}, log_data[i], wds[i]);
    end
  endtask

  initial begin
    int n, gap;
    logic [15:0] pc;
    do_reset();
    @(negedge clk);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_bus_own", bus_own, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_pc_init", pc_init, 0);
    tick();

    // T1: two-word program at PC 14
    wds[0] = 32'h00050693; wds[1] = 32'h00000713;
    build(16'h000E, 16'd2, 2, 0);
    send_stream(999, 0);
    wait_end(200);
    tick();
    chk("t1_nwrites", log_data.size(), 2);
    if (log_data.size() >= 2) begin
      chk("t1_addr0", log_addr[0], 0);
      chk("t1_data0", log_data[0], 32'h00050693);
      chk("t1_addr1", log_addr[1], 1);
      chk("t1_data1", log_data[1], 32'h00000713);
    end
    chk("t1_pc_init", pc_init, 14);
    chk("t1_done", done, 1);
`ifdef BOOT_CHECKSUM_EN
    chk("t1_release_delay", first_run_cyc - last_write_cyc, 6);
`else
    chk("t1_release_delay", first_run_cyc - last_write_cyc, 5);
`endif
    in_data = 8'hA5; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("t1_trailing_done", done, 1);

    // T2: empty program
    do_reset();
    build(16'h0003, 16'd0, 0, 0);
    send_stream(999, 0);
    wait_end(100);
    tick();
    chk("t2_nwrites", log_data.size(), 0);
    chk("t2_pc_init", pc_init, 3);
    chk("t2_done", done, 1);
    chk("t2_cpu_reset", cpu_reset, 0);

    // T3: oversized word count
    do_reset();
    build(16'h0010, 16'h8001, 0, 0);
    send_stream(4, 0);
    @(negedge clk);
    chk("t3_error", error, 1);
    chk("t3_cpu_reset", cpu_reset, 1);
    chk("t3_bus_own", bus_own, 0);
    repeat (5) tick();
    chk("t3_error_sticky", error, 1);
    chk("t3_nwrites", log_data.size(), 0);

    // T4: gappy valid across the words
    do_reset();
    for (int i = 0; i < 3; i++) wds[i] = $urandom;
    build(16'h0100, 16'd3, 3, 0);
    send_stream(999, 60);
    wait_end(400);
    tick();
    check_log("t4", 3);
    chk("t4_done", done, 1);

    // T5: reload in the middle of word 3, then a fresh stream
    do_reset();
    for (int i = 0; i < 5; i++) wds[i] = $urandom;
    build(16'h0200, 16'd5, 5, 0);
    send_stream(4 + 8 + 2, 0);
    pulse_reload();
    @(negedge clk);
    chk("t5_cpu_reset", cpu_reset, 1);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_done", done, 0);
    chk("t5_nwrites_cleared", log_data.size(), 0);
    tick();
    for (int i = 0; i < 3; i++) wds[i] = $urandom;
    build(16'h0007, 16'd3, 3, 0);
    send_stream(999, 20);
    wait_end(400);
    tick();
    check_log("t5", 3);
    chk("t5_pc_init", pc_init, 7);

`ifdef BOOT_CHECKSUM_EN
    // T6: checksum good and corrupted
    do_reset();
    wds[0] = 32'h12345678;
    build(16'h0004, 16'd1, 1, 0);
    send_stream(999, 0);
    wait_end(100);
    tick();
    chk("t6_good_done", done, 1);
    do_reset();
    build(16'h0004, 16'd1, 1, 1);
    send_stream(999, 0);
    wait_end(100);
    tick();
    chk("t6_bad_error", error, 1);
    chk("t6_bad_cpu_reset", cpu_reset, 1);
`endif

    // Random streams, some aborted by reload, some with an illegal count.
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(1) == 1) do_reset();
      else                        pulse_reload();
      n  = int'($urandom_range(6));
      pc = 16'($urandom);
      gap = int'($urandom_range(50));
      for (int i = 0; i < n; i++) wds[i] = $urandom;
      if ($urandom_range(9) == 0) begin
        build(pc, 16'hFFFF, 0, 0);
        send_stream(4, gap);
        tick();
        chk("rnd_bad_n_error", error, 1);
      end else if ($urandom_range(4) == 0) begin
        build(pc, 16'(n), n, 0);
        send_stream(int'($urandom_range(strm.size())), gap);
      end else begin
        build(pc, 16'(n), n, 0);
        send_stream(999, gap);
        wait_end(500);
        tick();
        check_log("rnd", n);
        chk("rnd_done", done, 1);
      end
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
